// File: rtl/audio_output_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_output_pkg
//  Description : Shared types and helpers for the audio output stage.
//                - output_state_t : OFF / ACTIVE / MUTING state encoding
//                - MUTE_STEP_DEFAULT : default per-tick soft-mute decrement
//                - to_offset_binary : two's complement -> offset binary
//  Revision    : 1.0  initial release
// ============================================================================
package audio_output_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ACTIVE = 2'd1,
        MUTING = 2'd2
    } output_state_t;

    localparam int unsigned MUTE_STEP_DEFAULT = 64;

    // Inverting the sign bit maps signed full scale onto 0..2^width-1, so the
    // most negative sample becomes 0 (constant-low bitstream).
    function automatic logic [31:0] to_offset_binary(input logic [31:0] value,
                                                     input int unsigned width);
        return value ^ (32'd1 << (width - 1));
    endfunction

endpackage : audio_output_pkg
`default_nettype wire

// File: rtl/audio_output_stage_pdm.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_modulator
//  Description : First-order delta-sigma modulator. The offset-binary sample
//                is added to the accumulator every cycle; the carry out is the
//                PDM bit, so the one-density equals u / 2^DATA_WIDTH.
//  Ports       : clk_i    - system clock
//                rst_i    - synchronous active-high reset
//                clear_i  - synchronous clear of accumulator and output bit
//                sample_i - signed two's complement sample
//                pdm_o    - registered PDM bitstream
//  Revision    : 1.0  initial release
// ============================================================================
module pdm_modulator
    import audio_output_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    output logic                  pdm_o
);

    logic [DATA_WIDTH-1:0] offset_val;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] acc_q;
    logic                  carry_q;

    assign offset_val = DATA_WIDTH'(to_offset_binary(32'(sample_i), DATA_WIDTH));

    // Only the low DATA_WIDTH bits are kept; the carry out of the sum is the
    // accumulator's top bit and lives in carry_q.
    assign sum = {1'b0, acc_q} + {1'b0, offset_val};

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= sum[DATA_WIDTH-1:0];
            carry_q <= sum[DATA_WIDTH];
        end
    end

    assign pdm_o = carry_q;

endmodule : pdm_modulator
`default_nettype wire

// File: rtl/audio_output_stage.sv
`default_nettype none
// ============================================================================
//  Module      : audio_output_stage
//  Description : Captures the mixed wave once per programmable sample period,
//                drives it through a first-order PDM modulator and sequences
//                the amplifier with a soft-mute ramp so shutdown does not pop.
//  Ports       : clk_i            - system clock
//                rst_i            - synchronous active-high reset
//                enable_i         - 1 = play, 0 = soft-mute then power down
//                sample_divider_i - sample period in clocks minus 1
//                sample_i         - signed Q1.15 mixed wave
//                sample_tick_o    - pulse on each capture or mute step
//                pdm_o            - PDM bitstream to the audio pin
//                amp_enable_o     - external amplifier enable
//                idle_o           - high while powered down (OFF)
//  Revision    : 1.0  initial release
// ============================================================================
module audio_output_stage
    import audio_output_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned MUTE_STEP  = MUTE_STEP_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [DIV_WIDTH-1:0]  sample_divider_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    output logic                  sample_tick_o,
    output logic                  pdm_o,
    output logic                  amp_enable_o,
    output logic                  idle_o
);

    localparam logic [DATA_WIDTH-1:0] STEP     = DATA_WIDTH'(MUTE_STEP);
    localparam logic [DATA_WIDTH:0]   STEP_EXT = (DATA_WIDTH+1)'(MUTE_STEP);

    output_state_t         state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
    logic                  sample_tick_q, sample_tick_d;
    logic [DATA_WIDTH-1:0] held_q, held_d;

    logic                  tick;
    logic                  held_neg;
    logic [DATA_WIDTH:0]   held_ext;
    logic [DATA_WIDTH:0]   held_mag;
    logic                  held_small;
    logic                  mod_clear;

    // ------------------------------------------------------------------------
    // Tick generator. '>=' lets a divider lowered below the running count take
    // effect on the very next cycle instead of waiting for a counter wrap.
    // ------------------------------------------------------------------------
    assign tick      = (div_cnt_q >= sample_divider_i);
    assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

    // Magnitude is formed one bit wider so that 0x8000 has a representable
    // absolute value.
    assign held_neg   = held_q[DATA_WIDTH-1];
    assign held_ext   = {held_neg, held_q};
    assign held_mag   = held_neg ? (~held_ext + 1'b1) : held_ext;
    assign held_small = (held_mag <= STEP_EXT);

    // ------------------------------------------------------------------------
    // Enable / soft-mute state machine
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        held_d        = held_q;
        sample_tick_d = 1'b0;

        case (state_q)
            OFF: begin
                held_d = '0;
                if (enable_i) begin
                    state_d = ACTIVE;
                end
            end

            ACTIVE: begin
                sample_tick_d = tick;
                // A tick coinciding with enable falling is still a capture.
                if (tick) begin
                    held_d = sample_i;
                end
                if (!enable_i) begin
                    state_d = MUTING;
                end
            end

            MUTING: begin
                sample_tick_d = tick;
                if (enable_i) begin
                    // Re-enable wins over a mute step on the same tick.
                    state_d = ACTIVE;
                    if (tick) begin
                        held_d = sample_i;
                    end
                end else if (tick) begin
                    if (held_small) begin
                        held_d  = '0;
                        state_d = OFF;
                    end else if (held_neg) begin
                        held_d = held_q + STEP;
                    end else begin
                        held_d = held_q - STEP;
                    end
                end
            end

            default: begin
                state_d = OFF;
                held_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= OFF;
            div_cnt_q     <= '0;
            sample_tick_q <= 1'b0;
            held_q        <= '0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            sample_tick_q <= sample_tick_d;
            held_q        <= held_d;
        end
    end

    // Clearing on the next state makes the PDM bit low in the first OFF cycle,
    // together with the amplifier enable dropping.
    assign mod_clear = (state_d == OFF);

    pdm_modulator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pdm_modulator (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (mod_clear),
        .sample_i (held_q),
        .pdm_o    (pdm_o)
    );

    assign sample_tick_o = sample_tick_q;
    assign amp_enable_o  = (state_q != OFF);
    assign idle_o        = (state_q == OFF);

endmodule : audio_output_stage
`default_nettype wire

// File: tb/tb_audio_output_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_audio_output_stage
//  Description : Directed self-checking bench for audio_output_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_audio_output_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] divider;
    logic [15:0] sample;
    logic        sample_tick;
    logic        pdm;
    logic        amp_enable;
    logic        idle;

    int checks = 0;
    int errors = 0;

    audio_output_stage dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .sample_divider_i (divider),
        .sample_i         (sample),
        .sample_tick_o    (sample_tick),
        .pdm_o            (pdm),
        .amp_enable_o     (amp_enable),
        .idle_o           (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance until sample_tick is seen, bounded.
    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (sample_tick !== 1'b1 && n < 2000);
        check(tag, {31'd0, sample_tick}, 32'd1);
    endtask

    // Count ones of pdm over the next n cycles.
    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (pdm === 1'b1) ones++;
        end
    endtask

    // Drop enable right after a capture tick and follow the ramp to OFF.
    task automatic mute_run(input string tag, input logic [15:0] e0,
                            input logic [15:0] e1, input logic [15:0] e2);
        logic [15:0] seen [4];
        int k = 0;
        int cyc = 0;
        for (int i = 0; i < 4; i++) seen[i] = 16'hDEAD;
        enable = 1'b0;
        while (amp_enable === 1'b1 && cyc < 64) begin
            step(1);
            cyc++;
            if (sample_tick === 1'b1 && k < 4) begin
                seen[k] = dut.held_q;
                k++;
            end
        end
        check({tag, "_cycles"}, cyc, 32'd16);
        check({tag, "_held0"}, {16'd0, seen[0]}, {16'd0, e0});
        check({tag, "_held1"}, {16'd0, seen[1]}, {16'd0, e1});
        check({tag, "_held2"}, {16'd0, seen[2]}, {16'd0, e2});
        check({tag, "_held3"}, {16'd0, seen[3]}, 32'd0);
        check({tag, "_idle"}, {31'd0, idle}, 32'd1);
        check({tag, "_pdm"}, {31'd0, pdm}, 32'd0);
    endtask

    initial begin
        int   ones;
        logic amp_ok;

        // ---------------- reset ----------------
        rst     = 1'b1;
        enable  = 1'b0;
        divider = 16'd3;
        sample  = 16'h0000;
        step(3);
        check("rst_pdm",  {31'd0, pdm},         32'd0);
        check("rst_amp",  {31'd0, amp_enable},  32'd0);
        check("rst_idle", {31'd0, idle},        32'd1);
        check("rst_tick", {31'd0, sample_tick}, 32'd0);
        check("rst_held", {16'd0, dut.held_q},  32'd0);

        // ---------------- enable, sample 0 -> 50% density ----------------
        rst    = 1'b0;
        enable = 1'b1;
        step(1);
        check("en_amp",  {31'd0, amp_enable}, 32'd1);
        check("en_idle", {31'd0, idle},       32'd0);
        check("zero_pdm0", {31'd0, pdm}, 32'd0);
        step(1);
        check("zero_pdm1", {31'd0, pdm}, 32'd1);
        step(1);
        check("zero_pdm2", {31'd0, pdm}, 32'd0);
        check("tick_gap0", {31'd0, sample_tick}, 32'd0);
        step(1);
        check("zero_pdm3", {31'd0, pdm}, 32'd1);
        check("tick_first", {31'd0, sample_tick}, 32'd1);
        step(3);
        check("tick_gap3", {31'd0, sample_tick}, 32'd0);
        step(1);
        check("tick_period4", {31'd0, sample_tick}, 32'd1);

        // ---------------- density checks ----------------
        sample = 16'h8000;
        wait_tick("tick_8000");
        count_ones(16, ones);
        check("dens_8000", ones, 32'd0);

        sample = 16'h4000;
        wait_tick("tick_4000");
        count_ones(4, ones);
        check("dens_4000_w4", ones, 32'd3);
        count_ones(64, ones);
        check("dens_4000_w64", ones, 32'd48);

        sample = 16'h7FFF;
        wait_tick("tick_7fff");
        count_ones(65536, ones);
        check("dens_7fff_zeros", 65536 - ones, 32'd1);

        // ---------------- positive mute ramp ----------------
        sample = 16'h0100;
        wait_tick("tick_0100");
        check("held_0100", {16'd0, dut.held_q}, 32'h0100);
        mute_run("mute_pos", 16'h00C0, 16'h0080, 16'h0040);

        // ---------------- negative mute ramp ----------------
        sample = 16'hFF00;
        enable = 1'b1;
        wait_tick("tick_ff00");
        check("held_ff00", {16'd0, dut.held_q}, 32'hFF00);
        mute_run("mute_neg", 16'hFF40, 16'hFF80, 16'hFFC0);

        // ---------------- re-enable on a mute tick ----------------
        sample = 16'h0100;
        enable = 1'b1;
        wait_tick("tick_reen");
        enable = 1'b0;
        amp_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            amp_ok = amp_ok & (amp_enable === 1'b1);
        end
        enable = 1'b1;
        sample = 16'h1234;
        step(1);
        amp_ok = amp_ok & (amp_enable === 1'b1);
        check("reen_tick", {31'd0, sample_tick}, 32'd1);
        check("reen_held", {16'd0, dut.held_q}, 32'h1234);
        check("reen_amp_never_low", {31'd0, amp_ok}, 32'd1);
        sample = 16'h2222;
        wait_tick("tick_reen2");
        check("reen_active_capture", {16'd0, dut.held_q}, 32'h2222);

        // ---------------- divider change 1000 -> 5 at count 700 ----------------
        divider = 16'd1000;
        step(700);
        check("div_no_tick", {31'd0, sample_tick}, 32'd0);
        divider = 16'd5;
        step(1);
        check("div_tick_next", {31'd0, sample_tick}, 32'd1);
        step(5);
        check("div_gap", {31'd0, sample_tick}, 32'd0);
        step(1);
        check("div_period6_a", {31'd0, sample_tick}, 32'd1);
        step(6);
        check("div_period6_b", {31'd0, sample_tick}, 32'd1);

        // ---------------- final capture on enable fall ----------------
        step(5);
        sample = 16'h0180;
        enable = 1'b0;
        step(1);
        check("final_tick", {31'd0, sample_tick}, 32'd1);
        check("final_held", {16'd0, dut.held_q}, 32'h0180);
        check("final_amp",  {31'd0, amp_enable}, 32'd1);
        wait_tick("tick_final_mute");
        check("final_mute_step", {16'd0, dut.held_q}, 32'h0140);

        // ---------------- abrupt reset mid-operation ----------------
        step(2);
        rst = 1'b1;
        step(1);
        check("mid_rst_amp",  {31'd0, amp_enable},  32'd0);
        check("mid_rst_idle", {31'd0, idle},        32'd1);
        check("mid_rst_pdm",  {31'd0, pdm},         32'd0);
        check("mid_rst_tick", {31'd0, sample_tick}, 32'd0);
        check("mid_rst_held", {16'd0, dut.held_q},  32'd0);
        rst = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_audio_output_stage
`default_nettype wire

// File: doc/audio_output_stage.md
# audio_output_stage

Output stage directly downstream of the audio synthesis pipeline. Once per programmable sample period it captures the 16-bit signed mixed wave and holds it. It drives a first-order delta-sigma (PDM) modulator onto the board's mono audio pin. An enable/soft-mute state machine gates the external amplifier and ramps the held sample to zero before shutdown, so disabling the output does not pop.

## Interface
- `DATA_WIDTH`, 16: sample width; samples are signed Q1.15.
- `DIV_WIDTH`, 16: width of the sample-period divider.
- `MUTE_STEP`, 64: magnitude decrement applied to the held sample per tick while muting.

- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `enable_i`  in  1  level; 1 = play, 0 = soft-mute then power down.
- `sample_divider_i`  in  DIV_WIDTH  sample period in clocks, minus 1.
- `sample_i`  in  DATA_WIDTH  signed mixed wave, the synthesis pipeline's mixed output.
- `sample_tick_o`  out  1  one-cycle pulse on each sample capture or mute step.
- `pdm_o`  out  1  PDM bitstream to the audio pin.
- `amp_enable_o`  out  1  external amplifier enable (active-high).
- `idle_o`  out  1  high when the state is OFF.

## Operation
Tick generator:
- `div_cnt` counts up every cycle in every state.
- When `div_cnt >= sample_divider_i`: `div_cnt` returns to 0 and a tick occurs.
- Divider 0 gives a tick every cycle.
- Using `>=` makes a divider change that lands below the current count tick on the next cycle, never after a wrap.
- `sample_tick_o` is the registered tick, gated to states ACTIVE and MUTING.

States:
- **OFF**
  - `held` = 0, accumulator = 0, `pdm_o` = 0, `amp_enable_o` = 0.
  - `enable_i`=1 → ACTIVE.
- **ACTIVE**
  - `amp_enable_o` = 1.
  - On each tick, `held` <= `sample_i`.
  - `enable_i`=0 → MUTING. `held` is kept as is.
- **MUTING**
  - `amp_enable_o` = 1; no new captures.
  - On each tick:
    - if |`held`| <= `MUTE_STEP`: `held` <= 0 and → OFF.
    - otherwise `held` moves toward 0 by `MUTE_STEP`.
  - `enable_i`=1 → ACTIVE immediately; the next tick captures `sample_i` again.

Modulator (ACTIVE/MUTING only):
- Offset value u = `held` with its MSB inverted (offset binary, 0..65535).
- 17-bit accumulator: `acc` <= {0, `acc`[15:0]} + u.
- `pdm_o` <= carry bit 16 of that sum.
- One-density = u/65536.
- `held` = -32768 (0x8000) must give constant 0.

All arithmetic is unsigned DATA_WIDTH+1 bits. No saturation is needed.

## Timing
- Reset values: `pdm_o`=0, `amp_enable_o`=0, `sample_tick_o`=0, `idle_o`=1. `div_cnt`, `held` and `acc` all 0; state OFF.
- `sample_i` captured at tick cycle T affects `pdm_o` from cycle T+2: `held` is updated at T+1, `acc` and `pdm_o` at T+2.
- `amp_enable_o` rises 1 cycle after `enable_i` rises in OFF.
- `amp_enable_o` falls in the same cycle that the state enters OFF. `pdm_o` is 0 from that cycle.
- A tick in the same cycle as `enable_i` falling is a final capture: ACTIVE takes priority, so the sample is captured and then the state moves to MUTING.
- A tick in the same cycle as `enable_i` rising in MUTING captures `sample_i` and returns to ACTIVE. No mute step is applied.
- Reset asserted mid-operation returns everything to reset values on the next edge. Consequence: an abrupt stop, with no ramp.

## Structure
- Package `audio_output_pkg`, containing:
  - state enum `output_state_t` {OFF, ACTIVE, MUTING};
  - the default `MUTE_STEP`;
  - the offset-binary conversion function.
- Sub-module `pdm_modulator`:
  - inputs: `clk_i`, `rst_i`, `clear_i`, `sample_i`;
  - output: `pdm_o`;
  - contains the accumulator and the carry register.
- Tick generator and FSM stay in the top.

## Test plan
- Reset: hold `rst_i` 3 cycles → `pdm_o`=0, `amp_enable_o`=0, `idle_o`=1, no ticks.
- Divider=3, `enable_i`=1, `sample_i`=0x0000 → tick every 4 cycles; `pdm_o` alternates 0,1,0,1 (50% density); `amp_enable_o`=1 after 1 cycle.
- `sample_i`=0x8000 → `pdm_o` stuck at 0. `sample_i`=0x7FFF → exactly one 0 in every 65536 cycles. `sample_i`=0x4000 → 3 ones per 4 cycles.
- Mute with `held`=0x0100, divider=3, `enable_i` dropped:
  - `held` goes 0x00C0, 0x0080, 0x0040, then 0 on successive ticks, entering OFF;
  - `amp_enable_o` falls about 16 cycles after `enable_i` falls;
  - negative case: `held`=0xFF00 ramps up to 0 the same way.
- Re-enable during MUTING on a tick cycle → captures `sample_i`, state ACTIVE, `amp_enable_o` never drops.
- Divider changed from 1000 to 5 while `div_cnt`=700 → tick on the next cycle, then every 6 cycles.
